// File: rtl/serial_rx_framer.sv
//============================================================================
// Module   : serial_rx_framer
// Function : 8N1 serial receive framer feeding an external 8-bit SIPO.
//            Define SERIAL_RX_PARITY_EN for an even-parity bit after bit 7.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module serial_rx_framer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic CLOCK_50,
    input  logic Reset_n,
    input  logic Serial_In,
    output logic Serial_Data,
    output logic Shift_Flag,
    output logic Frame_Start,
    output logic Byte_Done,
    output logic Frame_Error,
`ifdef SERIAL_RX_PARITY_EN
    output logic Parity_Error,
`endif
    output logic Busy
);

    localparam int                 c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_STOP   = 3'd4;
    localparam logic [2:0] c_BREAK  = 3'd5;

    logic               r_sync1;
    logic               r_sync2;
    logic               w_rx;
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_next;
    logic               w_at_half;
    logic               w_at_full;
    logic               w_start;
    logic               w_shift;
    logic               w_done;
    logic               w_ferr;
`ifdef SERIAL_RX_PARITY_EN
    logic               r_parity;
    logic               w_perr;
`endif

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= Serial_In;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx      = r_sync2;
    assign w_at_half = (r_cnt == c_HALF_M1);
    assign w_at_full = (r_cnt == c_FULL_M1);

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_bit_next   = r_bit;
        case (r_state)
            c_IDLE: begin
                // IDLE also covers the cycle right after a stop decision,
                // so a start bit with no idle gap is still caught here.
                w_cnt_next = '0;
                w_bit_next = '0;
                if (!w_rx) begin
                    w_state_next = c_START;
                end
            end
            c_START: begin
                if (w_at_half) begin
                    w_cnt_next   = '0;
                    w_state_next = w_rx ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (w_at_full) begin
                    w_cnt_next = '0;
                    w_bit_next = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        w_state_next = c_PARITY;
`else
                        w_state_next = c_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            c_PARITY: begin
                if (w_at_full) begin
                    w_cnt_next   = '0;
                    w_state_next = c_STOP;
                end
            end
`endif
            c_STOP: begin
                if (w_at_full) begin
                    w_cnt_next   = '0;
                    w_state_next = w_rx ? c_IDLE : c_BREAK;
                end
            end
            c_BREAK: begin
                w_cnt_next = '0;
                if (w_rx) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_bit_next   = '0;
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_start = 1'b0;
        w_shift = 1'b0;
        w_done  = 1'b0;
        w_ferr  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        w_perr  = 1'b0;
`endif
        case (r_state)
            c_START: w_start = w_at_half & ~w_rx;
            c_DATA:  w_shift = w_at_full;
            c_STOP: begin
                if (w_at_full) begin
                    if (!w_rx) begin
                        w_ferr = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                    end else if (r_parity) begin
                        w_perr = 1'b1;
`endif
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Strobes are registered one cycle after the sample decision so that
    // Serial_Data and Shift_Flag become valid together.
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            Serial_Data  <= 1'b1;
            Shift_Flag   <= 1'b0;
            Frame_Start  <= 1'b0;
            Byte_Done    <= 1'b0;
            Frame_Error  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            Parity_Error <= 1'b0;
`endif
        end else begin
            if (w_shift) begin
                Serial_Data <= w_rx;
            end
            Shift_Flag   <= w_shift;
            Frame_Start  <= w_start;
            Byte_Done    <= w_done;
            Frame_Error  <= w_ferr;
`ifdef SERIAL_RX_PARITY_EN
            Parity_Error <= w_perr;
`endif
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    // Running XOR over data and parity bits; nonzero at STOP means odd total.
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_parity <= 1'b0;
        end else if (w_start) begin
            r_parity <= 1'b0;
        end else if (w_at_full && (r_state == c_DATA || r_state == c_PARITY)) begin
            r_parity <= r_parity ^ w_rx;
        end
    end
`endif

    assign Busy = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: doc/serial_rx_framer.md
SERIAL_RX_FRAMER -- requirements
Module: serial_rx_framer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set CLOCK_50 cycles per serial bit (115200 baud); legal range 8..65535.
REQ-002 CLOCK_50  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Reset_n  input  1  asynchronous active-low reset.
REQ-004 Serial_In  input  1  asynchronous serial line; idle high, 8N1 framing, LSB first.
REQ-005 Serial_Data  output  1  registered sampled data bit for the downstream 8-bit SIPO.
REQ-006 Shift_Flag  output  1  one-cycle strobe; Serial_Data SHALL be valid in the same cycle.
REQ-007 Frame_Start  output  1  one-cycle pulse on confirmed start bit; clears the downstream SIPO.
REQ-008 Byte_Done  output  1  one-cycle pulse; the downstream SIPO holds a complete byte.
REQ-009 Frame_Error  output  1  one-cycle pulse on a low stop bit.
REQ-010 Busy  output  1  high in any state other than IDLE.

Function
REQ-011 Serial_In SHALL pass through a 2-flop synchronizer (reset value 1); all decisions SHALL use the synchronized value "rx".
REQ-012 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP, and BREAK; a bit counter 0..7 and a cycle counter of ceil(log2(CLKS_PER_BIT)) bits SHALL be kept.
REQ-013 IDLE: rx low SHALL enter START with the cycle counter at 0.
REQ-014 START: when the cycle counter reaches CLKS_PER_BIT/2-1 (integer division), rx low SHALL pulse Frame_Start and enter DATA; rx high SHALL treat the low as a glitch and return to IDLE without pulsing anything.
REQ-015 DATA: every CLKS_PER_BIT cycles after entry, rx SHALL be sampled; the next cycle SHALL assert Shift_Flag with Serial_Data equal to that sample; after bit 7, the block SHALL enter STOP (or PARITY).
REQ-016 Exactly 8 Shift_Flag pulses SHALL occur per accepted frame, spaced CLKS_PER_BIT cycles apart.
REQ-017 Serial_Data SHALL hold its last value between strobes.
REQ-018 STOP: CLKS_PER_BIT cycles after the last data sample, rx high SHALL pulse Byte_Done and go to IDLE; rx low SHALL pulse Frame_Error and go to BREAK.
REQ-019 BREAK SHALL wait for rx high, then go to IDLE; no falling edge is recognised while in BREAK.
REQ-020 Byte_Done and Frame_Error SHALL never be high in the same cycle.
REQ-021 Shift_Flag SHALL be asserted only in DATA-derived cycles.
REQ-022 A start bit beginning in the cycle that STOP returns to IDLE SHALL be detected (back-to-back frames, no idle gap required).

Reset
REQ-023 Reset_n low SHALL immediately force state IDLE, both counters to 0, synchronizer flops to 1, Serial_Data to 1, and Shift_Flag, Frame_Start, Byte_Done, Frame_Error, and Busy to 0.
REQ-024 Reset mid-frame SHALL abandon the frame with no further pulses; after release, the first falling edge SHALL start a new frame.

Configuration
REQ-025 With macro SERIAL_RX_PARITY_EN defined, an even-parity bit SHALL follow bit 7 and be sampled in state PARITY, and output Parity_Error (1 bit, reset 0) SHALL exist.
REQ-026 When the parity check fails, the block SHALL pulse Parity_Error at the stop-bit decision instead of Byte_Done; a low stop bit SHALL still take priority as Frame_Error.
REQ-027 Without SERIAL_RX_PARITY_EN, the block SHALL have no PARITY state, no Parity_Error port, and 8N1 timing only.

Verification (CLKS_PER_BIT=16)
REQ-028 Stimulus: frame 0xA5 at 16 cycles/bit. Response: 8 Shift_Flag pulses with Serial_Data 1,0,1,0,0,1,0,1; one Frame_Start; one Byte_Done; SIPO model = 0xA5.
REQ-029 Stimulus: a 4-cycle low glitch on an idle line. Response: no Frame_Start, no Shift_Flag, Busy returns to 0 within 10 cycles.
REQ-030 Stimulus: frame 0x3C with the stop bit held low for 40 cycles. Response: one Frame_Error, no Byte_Done, Busy stays high until rx goes high.
REQ-031 Stimulus: frames 0x00 then 0xFF back-to-back. Response: two Byte_Done pulses; SIPO model yields 0x00 then 0xFF.
REQ-032 Stimulus: Reset_n pulsed low after the 3rd Shift_Flag of frame 0x55, then frame 0x81 sent. Response: outputs at reset values during reset; only 0x81 completes.
REQ-033 Stimulus (SERIAL_RX_PARITY_EN): 0x07 sent with parity 0. Response: Parity_Error pulse and no Byte_Done; 0x07 with parity 1 yields Byte_Done.
